fft2d_sequencer: RTL and testbench
==================================

# fft2d_sequencer

Controller that runs a complete N×N 2D FFT on one streaming 1D FFT core and one shared frame buffer. It configures the core, streams the buffer row by row into the core and writes each result row back in place. After the row pass drains, it streams the buffer column by column and writes each result column back in place. It replaces free-running count-threshold sequencing with handshake-driven control and sits between the frame-buffer RAM and the FFT core's AXI-Stream config, data-in and data-out channels.

## Interface
Parameters:
- LOG2N, 7: log2 of transform size; N = 2^LOG2N, frame = N×N samples.
- DW, 16: width of real and imaginary parts each.
- SCALE_SCH, 15'h0: scaling schedule placed in cfg_tdata[15:1].

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low.
- start  in  1  one-cycle request; sampled only in IDLE.
- inverse  in  1  sampled with start; 1 = inverse transform.
- busy  out  1  high from start acceptance until done.
- done  out  1  one-cycle pulse when the column pass has fully written back.
- err  out  1  sticky tlast mismatch flag; cleared on start acceptance.
- pass  out  1  0 = row pass, 1 = column pass.
- cfg_tdata  out  16  {SCALE_SCH, ~inverse}.
- cfg_tvalid  out  1 / cfg_tready  in  1.
- rd_en  out  1 / rd_addr  out  2*LOG2N  frame-buffer read. Data is valid 1 cycle after rd_en.
- rd_data  in  2*DW  {imag, real}.
- s_tdata  out  2*DW / s_tvalid  out  1 / s_tready  in  1 / s_tlast  out  1  to core input.
- m_tdata  in  2*DW / m_tvalid  in  1 / m_tready  out  1 / m_tlast  in  1  from core output.
- wr_en  out  1 / wr_addr  out  2*LOG2N / wr_data  out  2*DW  frame-buffer write.

## Operation
- States: IDLE → CFG → FEED → DRAIN → (pass 0: FEED again with pass=1; pass 1: DONE) → IDLE.
- IDLE: start latches inverse, clears err, sets busy and goes to CFG.
- CFG: holds cfg_tvalid=1 until cfg_tready is high on a rising edge, then enters FEED with pass=0. The core is configured once per frame.
- Input counters: in_line and in_idx, each LOG2N bits. in_idx is the fast counter.
  - Row pass: rd_addr = {in_line, in_idx}.
  - Column pass: rd_addr = {in_idx, in_line}.
- s_tlast = 1 on the beat with in_idx = N-1.
- FEED ends once N² beats have been accepted (s_tvalid & s_tready), then goes to DRAIN. Reads stop at N² issued.
- Output counters: out_line and out_idx, with the same address mapping as the input counters.
  - m_tready = 1 in FEED and DRAIN, 0 elsewhere.
  - Each m_tvalid beat produces wr_en=1, wr_data=m_tdata and the mapped wr_addr in the same cycle (combinational).
- DRAIN ends when N² output beats have been written. This guarantees no column read precedes the last row write.
- tlast check: on any output beat, if m_tlast != (out_idx==N-1), err is set.
- DONE: done=1 for one cycle, busy drops, return to IDLE.
- start while busy is ignored.
- Output beats outside FEED/DRAIN are not accepted (m_tready=0) and are not written.

## Timing
- Reset values: busy, done, err, pass, cfg_tvalid, rd_en, s_tvalid, s_tlast, m_tready, wr_en are 0. cfg_tdata is {SCALE_SCH,1'b1}. All addresses and data are 0.
- start at edge k: busy=1 and cfg_tvalid=1 from k+1.
- First rd_en is in the cycle after cfg handshake. First s_tvalid follows 1 cycle later.
- When s_tready is held high, one beat is accepted per cycle with no bubbles. Minimum frame time is 2·(N² + core latency) + 4 cycles.
- s_tready low: s_tdata and s_tlast stay stable and s_tvalid stays high. No read is lost or duplicated. The read pipeline holds at most 2 outstanding words.
- Pass boundary: pass flips in the cycle DRAIN completes. The first column-pass read occurs the next cycle.
- Asynchronous reset mid-frame returns to IDLE with reset values immediately. There is no resume.

## Structure
- Shared package fft2d_pkg holds:
  - state enum (IDLE, CFG, FEED, DRAIN, DONE)
  - address-map function map_addr(pass, line, idx)
  - cfg word builder
- One sub-module, fft2d_rd_stream: converts the 1-cycle-latency RAM read port to AXI-Stream using a 2-entry skid. Ports are enable-in, addr-in, rd_en/rd_data and s_* out. The FSM, counters, write path and tlast checker stay in fft2d_sequencer.

## Test plan
- Reset: hold reset=0 for 3 cycles with random inputs → all outputs at reset values; start is ignored during reset.
- Full frame, LOG2N=2, core model = identity with 5-cycle latency, buffer preloaded with addr → after done, buffer equals the input. The write sequence is 0..15 in row pass, then 0,4,8,12,1,5,… in column pass. done pulses exactly once.
- Backpressure: s_tready toggles 1,0,0,1 repeating → exactly 32 accepted beats, none repeated or skipped. rd_addr order is identical to the unstalled run.
- tlast fault: model asserts m_tlast on beat 2 of row 0 → err=1 and stays set through done; next start clears it.
- cfg stall and start-while-busy: cfg_tready low for 10 cycles → no rd_en until the handshake. A second start during FEED → no effect, single done.
- Reset mid-column-pass: reset asserted at beat 5 of pass 1 → outputs return to reset values immediately. A fresh start then completes a normal frame.

Source files
------------

// File: rtl/fft2d_pkg.sv
// Shared types and helpers for the 2D FFT sequencer: FSM states,
// frame-buffer address mapping and the core config word.
package fft2d_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CFG,
        S_FEED,
        S_DRAIN,
        S_DONE
    } state_e;

    // Row pass walks {line, idx}; column pass transposes to {idx, line}.
    function automatic logic [31:0] map_addr(input logic        pass_i,
                                             input logic [15:0] line_i,
                                             input logic [15:0] idx_i,
                                             input int unsigned log2n_i);
        logic [31:0] hi;
        logic [31:0] lo;
        hi = pass_i ? {16'h0, idx_i}  : {16'h0, line_i};
        lo = pass_i ? {16'h0, line_i} : {16'h0, idx_i};
        return (hi << log2n_i) | lo;
    endfunction

    function automatic logic [15:0] cfg_word(input logic [14:0] sch_i,
                                             input logic        inverse_i);
        return {sch_i, ~inverse_i};
    endfunction

endpackage

// File: rtl/fft2d_rd_stream.sv
// Turns a 1-cycle-latency RAM read port into an AXI-Stream source.
// A read issues only when its word is guaranteed a slot in the 2-entry skid.
module fft2d_rd_stream #(
    parameter int unsigned AW  = 14,
    parameter int unsigned DW2 = 32
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           en_i,
    input  logic [AW-1:0]  addr_i,
    input  logic           last_i,
    output logic           issue_o,
    output logic           rd_en_o,
    output logic [AW-1:0]  rd_addr_o,
    input  logic [DW2-1:0] rd_data_i,
    output logic [DW2-1:0] s_tdata_o,
    output logic           s_tvalid_o,
    input  logic           s_tready_i,
    output logic           s_tlast_o
);
    logic [DW2:0] skid_q [2];
    logic [1:0]   cnt_q;
    logic         inflight_q;
    logic         inflight_last_q;
    logic [1:0]   occ;
    logic         pop;
    logic         push;
    logic [DW2:0] incoming;

    always_comb begin
        incoming   = {inflight_last_q, rd_data_i};
        occ        = cnt_q + {1'b0, inflight_q};
        s_tvalid_o = (cnt_q != 2'd0) || inflight_q;
        if (cnt_q != 2'd0)   {s_tlast_o, s_tdata_o} = skid_q[0];
        else if (inflight_q) {s_tlast_o, s_tdata_o} = incoming;
        else                 {s_tlast_o, s_tdata_o} = '0;
        pop  = s_tvalid_o && s_tready_i;
        // Arriving word bypasses the skid only when it is consumed on arrival
        push      = inflight_q && !((cnt_q == 2'd0) && s_tready_i);
        issue_o   = en_i && ((occ - {1'b0, pop}) <= 2'd1);
        rd_en_o   = issue_o;
        rd_addr_o = issue_o ? addr_i : '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            skid_q[0]       <= '0;
            skid_q[1]       <= '0;
            cnt_q           <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
        end else begin
            inflight_q      <= issue_o;
            inflight_last_q <= issue_o && last_i;
            if ((cnt_q != 2'd0) && s_tready_i) begin
                skid_q[0] <= skid_q[1];
                if (push) begin
                    if (cnt_q == 2'd1) skid_q[0] <= incoming;
                    else               skid_q[1] <= incoming;
                end
                cnt_q <= push ? cnt_q : cnt_q - 2'd1;
            end else if (push) begin
                skid_q[cnt_q[0]] <= incoming;
                cnt_q            <= cnt_q + 2'd1;
            end
        end
    end

endmodule

// File: rtl/fft2d_sequencer.sv
// Runs an NxN 2D FFT on one streaming 1D core: row pass, then column pass,
// each streamed from the frame buffer and written back in place.
module fft2d_sequencer
    import fft2d_pkg::*;
#(
    parameter int unsigned LOG2N     = 7,
    parameter int unsigned DW        = 16,
    parameter logic [14:0] SCALE_SCH = 15'h0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 inverse,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic                 pass,
    output logic [15:0]          cfg_tdata,
    output logic                 cfg_tvalid,
    input  logic                 cfg_tready,
    output logic                 rd_en,
    output logic [2*LOG2N-1:0]   rd_addr,
    input  logic [2*DW-1:0]      rd_data,
    output logic [2*DW-1:0]      s_tdata,
    output logic                 s_tvalid,
    input  logic                 s_tready,
    output logic                 s_tlast,
    input  logic [2*DW-1:0]      m_tdata,
    input  logic                 m_tvalid,
    output logic                 m_tready,
    input  logic                 m_tlast,
    output logic                 wr_en,
    output logic [2*LOG2N-1:0]   wr_addr,
    output logic [2*DW-1:0]      wr_data
);
    localparam int unsigned AW = 2 * LOG2N;
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] LASTBEAT = {1'b0, {AW{1'b1}}};

    state_e           state_q;
    logic             busy_q, done_q, err_q, pass_q, cfg_valid_q, inv_q;
    logic [CW-1:0]    in_cnt_q, acc_cnt_q, out_cnt_q;
    logic [LOG2N-1:0] in_line, in_idx, out_line, out_idx;
    logic [AW-1:0]    rd_map, wr_map;
    logic             feed_en, issue, beat_in, beat_out, drain_done;

    assign in_idx   = in_cnt_q[LOG2N-1:0];
    assign in_line  = in_cnt_q[AW-1:LOG2N];
    assign out_idx  = out_cnt_q[LOG2N-1:0];
    assign out_line = out_cnt_q[AW-1:LOG2N];

    assign rd_map = AW'(map_addr(pass_q, 16'(in_line), 16'(in_idx), LOG2N));
    assign wr_map = AW'(map_addr(pass_q, 16'(out_line), 16'(out_idx), LOG2N));

    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign pass       = pass_q;
    assign cfg_tvalid = cfg_valid_q;
    assign cfg_tdata  = cfg_word(SCALE_SCH, inv_q);

    assign feed_en  = (state_q == S_FEED) && !in_cnt_q[AW];
    assign beat_in  = s_tvalid && s_tready;
    assign m_tready = (state_q == S_FEED) || (state_q == S_DRAIN);
    assign beat_out = m_tvalid && m_tready;
    assign wr_en    = beat_out;
    assign wr_addr  = beat_out ? wr_map : '0;
    assign wr_data  = beat_out ? m_tdata : '0;
    // Output beats may already be complete on entry to DRAIN
    assign drain_done = out_cnt_q[AW] || (beat_out && (out_cnt_q == LASTBEAT));

    fft2d_rd_stream #(
        .AW  (AW),
        .DW2 (2 * DW)
    ) u_rd_stream (
        .clk        (clk),
        .reset      (reset),
        .en_i       (feed_en),
        .addr_i     (rd_map),
        .last_i     (in_idx == '1),
        .issue_o    (issue),
        .rd_en_o    (rd_en),
        .rd_addr_o  (rd_addr),
        .rd_data_i  (rd_data),
        .s_tdata_o  (s_tdata),
        .s_tvalid_o (s_tvalid),
        .s_tready_i (s_tready),
        .s_tlast_o  (s_tlast)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            pass_q      <= 1'b0;
            cfg_valid_q <= 1'b0;
            inv_q       <= 1'b0;
            in_cnt_q    <= '0;
            acc_cnt_q   <= '0;
            out_cnt_q   <= '0;
        end else begin
            done_q <= 1'b0;
            if (issue)   in_cnt_q  <= in_cnt_q + CW'(1);
            if (beat_in) acc_cnt_q <= acc_cnt_q + CW'(1);
            if (beat_out) begin
                out_cnt_q <= out_cnt_q + CW'(1);
                if (m_tlast != (out_idx == '1)) err_q <= 1'b1;
            end
            case (state_q)
                S_IDLE: if (start) begin
                    inv_q       <= inverse;
                    err_q       <= 1'b0;
                    busy_q      <= 1'b1;
                    cfg_valid_q <= 1'b1;
                    state_q     <= S_CFG;
                end
                S_CFG: if (cfg_tready) begin
                    cfg_valid_q <= 1'b0;
                    pass_q      <= 1'b0;
                    in_cnt_q    <= '0;
                    acc_cnt_q   <= '0;
                    out_cnt_q   <= '0;
                    state_q     <= S_FEED;
                end
                S_FEED: if (beat_in && (acc_cnt_q == LASTBEAT)) state_q <= S_DRAIN;
                S_DRAIN: if (drain_done) begin
                    in_cnt_q  <= '0;
                    acc_cnt_q <= '0;
                    out_cnt_q <= '0;
                    if (!pass_q) begin
                        pass_q  <= 1'b1;
                        state_q <= S_FEED;
                    end else begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    pass_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fft2d_sequencer.sv
// Bench for fft2d_sequencer at N=4: frame buffer and identity core with
// 5-cycle latency are modelled here; results checked against index arithmetic.
module tb_fft2d_sequencer;
    localparam int unsigned LOG2N = 2;
    localparam int unsigned N     = 4;
    localparam int unsigned NN    = 16;
    localparam logic [14:0] SCH   = 15'h1A5;

    logic        clk = 1'b0, reset = 1'b0, start = 1'b0, inverse = 1'b0;
    logic        busy, done, err, pass, cfg_tvalid, cfg_tready = 1'b0;
    logic [15:0] cfg_tdata;
    logic        rd_en, s_tvalid, s_tlast, m_tready, wr_en;
    logic [3:0]  rd_addr, wr_addr;
    logic [31:0] rd_data, s_tdata, wr_data;
    logic        s_tready = 1'b0, m_tvalid = 1'b0, m_tlast = 1'b0;
    logic [31:0] m_tdata = '0, rd_q = '0;

    always #5 clk = ~clk;
    assign rd_data = rd_q;

    fft2d_sequencer #(.LOG2N(LOG2N), .DW(16), .SCALE_SCH(SCH)) dut (
        .clk(clk), .reset(reset), .start(start), .inverse(inverse),
        .busy(busy), .done(done), .err(err), .pass(pass),
        .cfg_tdata(cfg_tdata), .cfg_tvalid(cfg_tvalid), .cfg_tready(cfg_tready),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    typedef struct {
        logic [31:0] d;
        logic        l;
        int unsigned due;
    } cbeat_t;

    typedef struct {
        logic        inv;
        int unsigned rdy_mode;
        int unsigned cfg_stall;
        logic        fault;
        logic        extra_start;
        logic        exp_err;
    } vec_t;

    logic [31:0] mem [NN];
    logic [31:0] init_mem [NN];
    cbeat_t      cq[$];
    int unsigned cyc = 0, phase = 0, core_out_n = 0, rdy_mode = 0;
    logic        fault_en = 1'b0, lst_m;
    int unsigned wr_log[$], wr_pass[$], wr_cyc[$], rd_log[$], rd_cyc[$];
    logic [31:0] acc_d[$];
    logic        acc_l[$];
    int unsigned hold_viol = 0, hs_viol = 0;
    logic        hold_pend = 1'b0, hold_l = 1'b0;
    logic [31:0] hold_d = '0;
    int unsigned nchk = 0, nerr = 0;

    // Frame buffer and identity core with 5-cycle latency.
    always @(posedge clk) begin
        cyc++;
        phase++;
        if (!reset) begin
            cq.delete();
            hold_pend = 1'b0;
            rd_q     <= $urandom;
            m_tvalid <= 1'($urandom);
            m_tdata  <= $urandom;
            m_tlast  <= 1'($urandom);
            s_tready <= 1'($urandom);
        end else begin
            if (hold_pend && (!s_tvalid || s_tdata != hold_d || s_tlast != hold_l)) hold_viol++;
            hold_pend = s_tvalid && !s_tready;
            hold_d    = s_tdata;
            hold_l    = s_tlast;
            if (wr_en != (m_tvalid && m_tready)) hs_viol++;
            rd_q <= rd_en ? mem[rd_addr] : $urandom;
            if (rd_en) begin
                rd_log.push_back(32'(rd_addr));
                rd_cyc.push_back(cyc);
            end
            if (s_tvalid && s_tready) begin
                cq.push_back('{d: s_tdata, l: s_tlast, due: cyc + 5});
                acc_d.push_back(s_tdata);
                acc_l.push_back(s_tlast);
            end
            if (m_tvalid && m_tready && cq.size() > 0) begin
                void'(cq.pop_front());
                core_out_n++;
            end
            if (wr_en) begin
                mem[wr_addr] = wr_data;
                wr_log.push_back(32'(wr_addr));
                wr_pass.push_back(32'(pass));
                wr_cyc.push_back(cyc);
            end
            if (cq.size() > 0 && cq[0].due <= cyc) begin
                lst_m = cq[0].l;
                if (fault_en && core_out_n == 2) lst_m = 1'b1;
                m_tvalid <= 1'b1;
                m_tdata  <= cq[0].d;
                m_tlast  <= lst_m;
            end else begin
                m_tvalid <= 1'b0;
                m_tdata  <= $urandom;
                m_tlast  <= 1'($urandom);
            end
            case (rdy_mode)
                0:       s_tready <= 1'b1;
                1:       s_tready <= ((phase % 4) == 0) || ((phase % 4) == 3);
                default: s_tready <= 1'($urandom);
            endcase
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // k-th beat of a frame: rows in order, then columns in order.
    function automatic int unsigned exp_addr(input int unsigned k);
        int unsigned j;
        j = k % NN;
        if (k < NN) return j;
        return (j % N) * N + j / N;
    endfunction

    task automatic check_reset_vals(input string nm);
        chk({nm, "_ctrl"}, 64'({busy, done, err, pass, cfg_tvalid, rd_en, s_tvalid,
                                s_tlast, m_tready, wr_en}), 64'(0));
        chk({nm, "_cfg"}, 64'(cfg_tdata), 64'({SCH, 1'b1}));
        chk({nm, "_addr"}, 64'({rd_addr, wr_addr}), 64'(0));
        chk({nm, "_data"}, {s_tdata, wr_data}, 64'(0));
    endtask

    task automatic clear_logs();
        wr_log.delete(); wr_pass.delete(); wr_cyc.delete();
        rd_log.delete(); rd_cyc.delete(); acc_d.delete(); acc_l.delete();
        core_out_n = 0; hold_viol = 0; hs_viol = 0;
    endtask

    task automatic run_frame(input vec_t v);
        int unsigned ndone, bad;
        logic        err_done, busy_done;
        for (int unsigned a = 0; a < NN; a++) begin
            init_mem[a] = $urandom;
            mem[a]      = init_mem[a];
        end
        clear_logs();
        rdy_mode = v.rdy_mode;
        fault_en = v.fault;
        @(negedge clk); start = 1'b1; inverse = v.inv;
        @(negedge clk); start = 1'b0; inverse = 1'($urandom);
        chk("start_busy_cfgv_err", 64'({busy, cfg_tvalid, err}), 64'(3'b110));
        chk("cfg_word", 64'(cfg_tdata), 64'({SCH, ~v.inv}));
        bad = 0;
        for (int unsigned c = 0; c < v.cfg_stall; c++) begin
            @(negedge clk);
            if (rd_en || !cfg_tvalid) bad++;
        end
        if (v.cfg_stall > 0) chk("cfg_stall_no_rd", 64'(bad), 64'(0));
        cfg_tready = 1'b1;
        @(negedge clk); cfg_tready = 1'b0;
        chk("first_rd_after_cfg", 64'({rd_en, cfg_tvalid, pass}), 64'(3'b100));
        @(negedge clk);
        chk("first_svalid", 64'(s_tvalid), 64'(1));
        if (v.extra_start) begin
            repeat (3) @(negedge clk);
            start = 1'b1;
            @(negedge clk); start = 1'b0;
            chk("start_while_busy", 64'({busy, cfg_tvalid}), 64'(2'b10));
        end
        ndone = 0; err_done = 1'b0; busy_done = 1'b1;
        for (int unsigned c = 0; c < 2000 && ndone == 0; c++) begin
            @(negedge clk);
            if (done) begin
                ndone++;
                err_done  = err;
                busy_done = busy;
            end
        end
        chk("done_seen", 64'(ndone), 64'(1));
        for (int unsigned c = 0; c < 6; c++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("done_once", 64'(ndone), 64'(1));
        chk("busy_at_done", 64'(busy_done), 64'(0));
        chk("busy_after", 64'(busy), 64'(0));
        chk("err_at_done", 64'(err_done), 64'(v.exp_err));
        chk("err_after", 64'(err), 64'(v.exp_err));
        chk("rd_count", 64'(rd_log.size()), 64'(2 * NN));
        chk("wr_count", 64'(wr_log.size()), 64'(2 * NN));
        chk("acc_count", 64'(acc_d.size()), 64'(2 * NN));
        bad = 0;
        for (int unsigned k = 0; k < 2 * NN; k++) begin
            if (k < rd_log.size() && rd_log[k] != exp_addr(k)) bad++;
            if (k < wr_log.size() && (wr_log[k] != exp_addr(k) || wr_pass[k] != k / NN)) bad++;
            if (k < acc_d.size() && (acc_d[k] != init_mem[exp_addr(k)] ||
                                     acc_l[k] != ((k % N) == N - 1))) bad++;
        end
        chk("addr_data_order", 64'(bad), 64'(0));
        bad = 0;
        for (int unsigned a = 0; a < NN; a++) if (mem[a] != init_mem[a]) bad++;
        chk("buffer_identity", 64'(bad), 64'(0));
        if (rd_cyc.size() > NN && wr_cyc.size() >= NN)
            chk("pass_boundary_gap", 64'(rd_cyc[NN] - wr_cyc[NN-1]), 64'(1));
        chk("s_hold_stable", 64'(hold_viol), 64'(0));
        chk("wr_follows_handshake", 64'(hs_viol), 64'(0));
    endtask

    vec_t tbl[5];

    initial begin
        int unsigned c;
        tbl[0] = '{inv: 1'b0, rdy_mode: 0, cfg_stall: 0,  fault: 1'b0, extra_start: 1'b0, exp_err: 1'b0};
        tbl[1] = '{inv: 1'b1, rdy_mode: 1, cfg_stall: 0,  fault: 1'b0, extra_start: 1'b0, exp_err: 1'b0};
        tbl[2] = '{inv: 1'b0, rdy_mode: 0, cfg_stall: 10, fault: 1'b0, extra_start: 1'b1, exp_err: 1'b0};
        tbl[3] = '{inv: 1'b0, rdy_mode: 2, cfg_stall: 2,  fault: 1'b1, extra_start: 1'b0, exp_err: 1'b1};
        tbl[4] = '{inv: 1'b1, rdy_mode: 0, cfg_stall: 3,  fault: 1'b0, extra_start: 1'b0, exp_err: 1'b0};
        for (int unsigned a = 0; a < NN; a++) mem[a] = '0;

        reset = 1'b0;
        for (int unsigned k = 0; k < 3; k++) begin
            start = 1'($urandom); inverse = 1'($urandom); cfg_tready = 1'($urandom);
            @(negedge clk);
            check_reset_vals("reset");
        end
        start = 1'b0; cfg_tready = 1'b0;
        @(negedge clk); reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_after_reset", 64'({busy, cfg_tvalid}), 64'(0));

        for (int unsigned i = 0; i < 5; i++) run_frame(tbl[i]);

        // Reset at beat 5 of the column pass, then a fresh frame.
        clear_logs();
        rdy_mode = 0; fault_en = 1'b0;
        @(negedge clk); start = 1'b1; inverse = 1'b0;
        @(negedge clk); start = 1'b0; cfg_tready = 1'b1;
        @(negedge clk); cfg_tready = 1'b0;
        c = 0;
        while (acc_d.size() < NN + 5 && c < 500) begin
            @(negedge clk);
            c++;
        end
        chk("mid_beats", 64'(acc_d.size()), 64'(NN + 5));
        chk("mid_pass", 64'(pass), 64'(1));
        reset = 1'b0;
        #1;
        check_reset_vals("mid_reset");
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("mid_idle", 64'({busy, done, m_tready}), 64'(0));
        run_frame(tbl[0]);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish by %0t", $time);
        $fatal(1);
    end

endmodule
